// File: rtl/uart_pkg.sv
// Shared UART definitions: frame decoder states, framing constants and small helpers
// used by uart_rx, uart_tx and uart_cmd_decoder.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_CHK
    } state_t;

    localparam logic [7:0] DEFAULT_SOF_BYTE = 8'h55;
    localparam int         FRAME_HDR_BYTES  = 3;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout counter for the command decoder; expire pulses for one cycle
// when the gap between bytes inside a frame reaches TIMEOUT_CYCLES.
module uart_frame_timer #(
    parameter int TIMEOUT_CYCLES = 27_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int                 TIMER_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] LAST_TICK = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] count;

    // Holds at the last tick instead of wrapping; the decoder returns to idle and clears it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && (count != LAST_TICK)) begin
            count <= count + 1'b1;
        end
    end

    assign expire = run && !clear && (count == LAST_TICK);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Assembles SOF/CMD/ADDR/DATA/CHK frames from the uart_rx byte stream and presents
// checksum-verified commands on a single-entry valid/ready buffer.
module uart_cmd_decoder
    import uart_pkg::*;
#(
    parameter int         DATA_BYTES     = 2,
    parameter logic [7:0] SOF_BYTE       = DEFAULT_SOF_BYTE,
    parameter int         TIMEOUT_CYCLES = 27_000
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic [7:0]              cmd_op,
    output logic [7:0]              cmd_addr,
    output logic [8*DATA_BYTES-1:0] cmd_data,
    output logic                    err_chk,
    output logic                    err_timeout,
    output logic                    err_overflow,
    output logic [15:0]             frame_cnt
);

    localparam int               IDX_W    = $clog2(DATA_BYTES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [7:0]              acc;
    logic [7:0]              op_buf;
    logic [7:0]              addr_buf;
    logic [8*DATA_BYTES-1:0] data_buf;
    logic [IDX_W-1:0]        byte_idx;

    logic timer_clear;
    logic timer_run;
    logic timer_expire;
    logic buf_free;
    logic chk_byte;
    logic chk_good;
    logic load_cmd;
    logic drop_overflow;
    logic drop_chk;

    uart_frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .resetn(resetn),
        .clear (timer_clear),
        .run   (timer_run),
        .expire(timer_expire)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A received byte always takes priority over an expiring timer.
    always_comb begin
        state_nxt = state;
        if (rx_valid) begin
            unique case (state)
                S_IDLE:  if (rx_data == SOF_BYTE) state_nxt = S_CMD;
                S_CMD:   state_nxt = S_ADDR;
                S_ADDR:  state_nxt = S_DATA;
                S_DATA:  if (byte_idx == LAST_IDX) state_nxt = S_CHK;
                S_CHK:   state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end else if (timer_expire) begin
            state_nxt = S_IDLE;
        end
    end

    always_comb begin
        timer_clear   = rx_valid || (state == S_IDLE);
        timer_run     = (state != S_IDLE);
        buf_free      = !cmd_valid || cmd_ready;
        chk_byte      = rx_valid && (state == S_CHK);
        chk_good      = (rx_data == acc);
        load_cmd      = chk_byte && chk_good && buf_free;
        drop_overflow = chk_byte && chk_good && !buf_free;
        drop_chk      = chk_byte && !chk_good;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc      <= '0;
            op_buf   <= '0;
            addr_buf <= '0;
            data_buf <= '0;
            byte_idx <= '0;
        end else if (state == S_IDLE) begin
            acc      <= '0;
            byte_idx <= '0;
        end else if (rx_valid) begin
            unique case (state)
                S_CMD: begin
                    op_buf <= rx_data;
                    acc    <= acc ^ rx_data;
                end
                S_ADDR: begin
                    addr_buf <= rx_data;
                    acc      <= acc ^ rx_data;
                end
                S_DATA: begin
                    for (int i = 0; i < DATA_BYTES; i++) begin
                        if (byte_idx == IDX_W'(i)) data_buf[8*i +: 8] <= rx_data;
                    end
                    acc      <= acc ^ rx_data;
                    byte_idx <= byte_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output buffer: a new frame may land in the same cycle the held one is consumed.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cmd_valid    <= 1'b0;
            cmd_op       <= '0;
            cmd_addr     <= '0;
            cmd_data     <= '0;
            err_chk      <= 1'b0;
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            err_chk      <= drop_chk;
            err_timeout  <= timer_expire;
            err_overflow <= drop_overflow;
            if (load_cmd) begin
                cmd_valid <= 1'b1;
                cmd_op    <= op_buf;
                cmd_addr  <= addr_buf;
                cmd_data  <= data_buf;
                frame_cnt <= sat_inc16(frame_cnt);
            end else if (cmd_ready) begin
                cmd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: directed frame scenarios plus randomized
// frames, compared against a frame-level model of expected commands and error pulses.
module tb_uart_cmd_decoder;

    localparam int         DATA_BYTES = 2;
    localparam int         TIMEOUT    = 64;
    localparam logic [7:0] SOF        = 8'h55;

    logic        clk = 1'b0;
    logic        resetn;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_op;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        err_chk;
    logic        err_timeout;
    logic        err_overflow;
    logic [15:0] frame_cnt;

    int          nChecks = 0;
    int          nPass   = 0;
    logic [31:0] expQ[$];
    logic        held;
    logic [15:0] expCnt;
    int          expChk, expTo, expOvf;
    int          gotChk = 0, gotTo = 0, gotOvf = 0;

    always #5 clk = ~clk;

    uart_cmd_decoder #(
        .DATA_BYTES    (DATA_BYTES),
        .SOF_BYTE      (SOF),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .err_chk     (err_chk),
        .err_timeout (err_timeout),
        .err_overflow(err_overflow),
        .frame_cnt   (frame_cnt)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nChecks++;
        if (observed === expected) nPass++;
        else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    function automatic logic [7:0] frameChk(input logic [7:0] op, input logic [7:0] addr, input logic [15:0] data);
        return op ^ addr ^ data[7:0] ^ data[15:8];
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        idle(gap);
    endtask

    task automatic setReady(input logic r);
        cmd_ready = r;
        if (r) held = 1'b0;
    endtask

    // Frame-level outcome: checksum, then whether a command is still waiting in the buffer.
    task automatic modelFrame(input logic [7:0] op, input logic [7:0] addr, input logic [15:0] data, input logic [7:0] chk);
        if (chk != frameChk(op, addr, data)) begin
            expChk++;
        end else if (held) begin
            expOvf++;
        end else begin
            expQ.push_back({op, addr, data});
            if (expCnt != 16'hFFFF) expCnt++;
            held = !cmd_ready;
        end
    endtask

    task automatic sendFrame(input logic [7:0] op, input logic [7:0] addr, input logic [15:0] data,
                             input logic [7:0] chk, input int maxGap, input int stretchIdx);
        logic [7:0] bytes [6];
        bytes = '{SOF, op, addr, data[7:0], data[15:8], chk};
        modelFrame(op, addr, data, chk);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) applyStimulus(bytes[i], 0);
            else if (i == stretchIdx) applyStimulus(bytes[i], TIMEOUT - 1);
            else applyStimulus(bytes[i], $urandom_range(maxGap, 0));
        end
    endtask

    // Every cycle: held command must match the oldest expected one; count error pulses.
    always @(negedge clk) begin
        if (resetn) begin
            checkOutput("err_exclusive", 64'($countones({err_chk, err_timeout, err_overflow}) <= 1), 64'(1));
            if (cmd_valid) begin
                checkOutput("cmd_pending", 64'(expQ.size() != 0), 64'(1));
                if (expQ.size() != 0) begin
                    checkOutput("cmd_fields", 64'({cmd_op, cmd_addr, cmd_data}), 64'(expQ[0]));
                    if (cmd_ready) void'(expQ.pop_front());
                end
            end
            if (err_chk) gotChk++;
            if (err_timeout) gotTo++;
            if (err_overflow) gotOvf++;
        end
    end

    initial begin
        logic [7:0]  op, addr, chk, junk;
        logic [15:0] data;

        resetn = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        cmd_ready = 1'b0;
        held = 1'b0;
        expCnt = 16'd0;
        expChk = 0;
        expTo = 0;
        expOvf = 0;
        idle(3);
        checkOutput("reset_valid", 64'(cmd_valid), 64'(0));
        checkOutput("reset_errs", 64'({err_chk, err_timeout, err_overflow}), 64'(0));
        checkOutput("reset_fields", 64'({cmd_op, cmd_addr, cmd_data}), 64'(0));
        checkOutput("reset_cnt", 64'(frame_cnt), 64'(0));
        resetn = 1'b1;
        idle(1);

        setReady(1'b1);
        sendFrame(8'h01, 8'h10, 16'h1234, frameChk(8'h01, 8'h10, 16'h1234), 2, -1);
        checkOutput("t1_valid", 64'(cmd_valid), 64'(1));
        checkOutput("t1_fields", 64'({cmd_op, cmd_addr, cmd_data}), 64'(32'h0110_1234));
        checkOutput("t1_cnt", 64'(frame_cnt), 64'(1));
        idle(1);
        checkOutput("t1_valid_drop", 64'(cmd_valid), 64'(0));

        sendFrame(8'h01, 8'h10, 16'h1234, 8'h00, 2, -1);
        checkOutput("t2_err_chk", 64'(err_chk), 64'(1));
        checkOutput("t2_valid", 64'(cmd_valid), 64'(0));
        idle(1);
        checkOutput("t2_err_pulse", 64'(err_chk), 64'(0));
        checkOutput("t2_cnt", 64'(frame_cnt), 64'(1));

        applyStimulus(SOF, 0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'h10, 0);
        expTo++;
        idle(TIMEOUT - 1);
        checkOutput("t3_timeout_early", 64'(err_timeout), 64'(0));
        idle(1);
        checkOutput("t3_timeout", 64'(err_timeout), 64'(1));
        idle(1);
        checkOutput("t3_timeout_pulse", 64'(err_timeout), 64'(0));
        sendFrame(8'hA5, 8'h3C, 16'hBEEF, frameChk(8'hA5, 8'h3C, 16'hBEEF), 1, -1);
        checkOutput("t3_recover", 64'({cmd_valid, cmd_op, cmd_addr, cmd_data}), 64'({1'b1, 32'hA53C_BEEF}));
        idle(2);

        // A byte arriving on the last timer tick is taken and the frame survives.
        sendFrame(8'h7E, 8'h81, 16'h0F0F, frameChk(8'h7E, 8'h81, 16'h0F0F), 1, 2);
        checkOutput("bw_valid", 64'(cmd_valid), 64'(1));
        idle(2);
        checkOutput("bw_no_timeout", 64'(gotTo), 64'(expTo));

        setReady(1'b0);
        sendFrame(8'h01, 8'h10, 16'h1234, frameChk(8'h01, 8'h10, 16'h1234), 2, -1);
        checkOutput("t4_first_valid", 64'(cmd_valid), 64'(1));
        idle(3);
        sendFrame(8'h02, 8'h20, 16'h0000, 8'h22, 2, -1);
        checkOutput("t4_overflow", 64'(err_overflow), 64'(1));
        checkOutput("t4_held", 64'({cmd_valid, cmd_op, cmd_addr, cmd_data}), 64'({1'b1, 32'h0110_1234}));
        idle(2);
        setReady(1'b1);
        idle(3);
        checkOutput("t4_consumed", 64'(cmd_valid), 64'(0));
        checkOutput("t4_queue", 64'(expQ.size()), 64'(0));
        checkOutput("t4_cnt", 64'(frame_cnt), 64'(expCnt));

        // Back-to-back: held command consumed in the same cycle the next one loads.
        setReady(1'b0);
        sendFrame(8'h11, 8'h22, 16'h3344, frameChk(8'h11, 8'h22, 16'h3344), 1, -1);
        applyStimulus(SOF, 0);
        applyStimulus(8'h66, 0);
        applyStimulus(8'h77, 0);
        applyStimulus(8'h88, 0);
        applyStimulus(8'h99, 0);
        setReady(1'b1);
        modelFrame(8'h66, 8'h77, 16'h9988, frameChk(8'h66, 8'h77, 16'h9988));
        applyStimulus(frameChk(8'h66, 8'h77, 16'h9988), 0);
        checkOutput("b2b_fields", 64'({cmd_valid, cmd_op, cmd_addr, cmd_data}), 64'({1'b1, 32'h6677_9988}));
        checkOutput("b2b_no_overflow", 64'(err_overflow), 64'(0));
        idle(2);

        applyStimulus(8'hAA, 1);
        applyStimulus(8'h00, 0);
        applyStimulus(8'hFF, 2);
        sendFrame(8'h55, 8'h55, 16'h0000, 8'h00, 1, -1);
        checkOutput("t5_fields", 64'({cmd_valid, cmd_op, cmd_addr, cmd_data}), 64'({1'b1, 32'h5555_0000}));
        idle(3);

        applyStimulus(SOF, 0);
        applyStimulus(8'h01, 0);
        resetn = 1'b0;
        idle(2);
        checkOutput("t6_valid", 64'(cmd_valid), 64'(0));
        checkOutput("t6_fields", 64'({cmd_op, cmd_addr, cmd_data}), 64'(0));
        checkOutput("t6_cnt", 64'(frame_cnt), 64'(0));
        expQ.delete();
        held = 1'b0;
        expCnt = 16'd0;
        resetn = 1'b1;
        idle(1);
        sendFrame(8'h0C, 8'hD0, 16'h00FF, frameChk(8'h0C, 8'hD0, 16'h00FF), 2, -1);
        checkOutput("t6_valid_after", 64'(cmd_valid), 64'(1));
        checkOutput("t6_cnt_after", 64'(frame_cnt), 64'(1));
        idle(2);

        for (int f = 0; f < 40; f++) begin
            setReady(1'($urandom_range(1, 0)));
            for (int j = 0; j < int'($urandom_range(2, 0)); j++) begin
                junk = 8'($urandom);
                if (junk == SOF) junk = 8'hAA;
                applyStimulus(junk, $urandom_range(2, 0));
            end
            op   = 8'($urandom);
            addr = 8'($urandom);
            data = 16'($urandom);
            if ($urandom_range(7, 0) == 0) begin
                applyStimulus(SOF, $urandom_range(2, 0));
                for (int k = 0; k < int'($urandom_range(4, 0)); k++) applyStimulus(8'($urandom), 1);
                expTo++;
                idle(TIMEOUT + 2);
            end else begin
                chk = frameChk(op, addr, data);
                if ($urandom_range(3, 0) == 0) chk = chk ^ 8'(1 << $urandom_range(7, 0));
                sendFrame(op, addr, data, chk, 3, -1);
                idle($urandom_range(3, 1));
            end
        end
        setReady(1'b1);
        idle(4);
        checkOutput("final_queue", 64'(expQ.size()), 64'(0));
        checkOutput("final_cnt", 64'(frame_cnt), 64'(expCnt));
        checkOutput("final_err_chk", 64'(gotChk), 64'(expChk));
        checkOutput("final_err_timeout", 64'(gotTo), 64'(expTo));
        checkOutput("final_err_overflow", 64'(gotOvf), 64'(expOvf));

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
